// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern transmitter: FSM encodings and the default
// pattern that the 1110010 detector bench also relies on.
package seq_gen_pkg;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StSend = 2'b01;
  localparam logic [1:0] StGap  = 2'b10;
  localparam logic [1:0] StDone = 2'b11;

  localparam int unsigned DefLen     = 7;
  localparam logic [6:0]  DefPattern = 7'b1110010;
  localparam int unsigned DefCntW    = 4;
  localparam int unsigned DefGapW    = 3;

endpackage

// File: rtl/seq_shreg.sv
// LEN-bit left-shifting register with synchronous load (priority over shift),
// asynchronous active-low clear and an MSB tap.
module seq_shreg #(
  parameter int unsigned LEN = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [LEN-1:0] din,
  output logic           msb
);

  logic [LEN-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {data_q[LEN-2:0], 1'b0};
    end
  end

  assign msb = data_q[LEN-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first, reps times, with gap idle cycles
// between frames. Outputs are registered, so they trail the FSM state by one cycle.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned    LEN     = DefLen,
  parameter logic [LEN-1:0] PATTERN = DefPattern,
  parameter int unsigned    CNT_W   = DefCntW,
  parameter int unsigned    GAP_W   = DefGapW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(LEN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             sh_load, sh_shift, sh_msb;
  logic             last_bit;

  seq_shreg #(
    .LEN (LEN)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (PATTERN),
    .msb   (sh_msb)
  );

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    last_bit    = (bit_cnt_q == BitW'(LEN - 1));

    unique case (state_q)
      StIdle: begin
        if (start && (reps != '0)) begin
          frame_cnt_d = reps;
          gap_len_d   = gap;
          bit_cnt_d   = '0;
          sh_load     = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        sh_shift  = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          // Explicit clear: LEN need not be a power of two.
          bit_cnt_d   = '0;
          frame_cnt_d = frame_cnt_q - 1'b1;
          if (frame_cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end else if (gap_len_q == '0) begin
            sh_load = 1'b1;
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          sh_load = 1'b1;
          state_d = StSend;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      out   <= (state_q == StSend) && sh_msb;
      valid <= (state_q == StSend);
      busy  <= (state_q == StSend) || (state_q == StGap);
      done  <= (state_q == StDone);
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a cycle-stamped model of the expected stream is queued on
// each accepted start and a negedge monitor pops and compares whatever the DUT presents.
module tb_seq_gen;

  localparam int Len = 7;

  typedef struct {
    int cyc;
    bit v;
    bit o;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b1;
  logic [3:0] reps = 4'd1;
  logic [2:0] gap = 3'd0;
  logic       out, valid, busy, done;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    free_at = 0;
  int    done_cnt = 0;
  item_t exp_q[$];
  int    done_q[$];
  int    det_q[$];
  bit [6:0] det_hist = '0;
  bit [6:0] pat = 7'b1110010;

  seq_gen u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .reps  (reps),
    .gap   (gap),
    .out   (out),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Start sampled at edge e: frames occupy cycles e+1 .. e+B, done at e+B+1, next accept e+B+2.
  task automatic model_start(input int e, input int r, input int g);
    int j;
    int b;
    if (r == 0 || e < free_at) return;
    b = r * Len + (r - 1) * g;
    j = 0;
    for (int f = 0; f < r; f++) begin
      for (int i = Len - 1; i >= 0; i--) begin
        exp_q.push_back('{cyc: e + 1 + j, v: 1'b1, o: pat[i]});
        j++;
      end
      if (f < r - 1) begin
        for (int k = 0; k < g; k++) begin
          exp_q.push_back('{cyc: e + 1 + j, v: 1'b0, o: 1'b0});
          j++;
        end
      end
    end
    done_q.push_back(e + 1 + b);
    free_at = e + b + 2;
  endtask

  task automatic send(input int r, input int g, output int e);
    @(negedge clk);
    #2;
    start = 1'b1;
    reps  = 4'(r);
    gap   = 3'(g);
    e     = cyc + 1;
    model_start(e, r, g);
    @(negedge clk);
    #2;
    start = 1'b0;
    reps  = 4'($urandom_range(0, 15));
    gap   = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: busy marks the cycles the DUT presents stream output.
  always @(negedge clk) begin
    item_t it;
    if (busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy", 1, 0);
      end else begin
        it = exp_q.pop_front();
        chk("busy_cycle", cyc, it.cyc);
        chk("valid", int'(valid), int'(it.v));
        chk("out", int'(out), int'(it.o));
      end
    end else begin
      chk("idle_valid_out", int'({valid, out}), 0);
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    det_hist = {det_hist[5:0], out};
    if (det_hist == 7'b1110010) det_q.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int d0;
    int b;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("reset_outputs", int'({out, valid, busy, done}), 0);
    end
    #1;
    start = 1'b0;
    rst   = 1'b1;
    free_at = 0;
    repeat (2) @(negedge clk);

    // Single frame.
    d0 = done_cnt;
    send(1, 0, e);
    wait_idle("single");
    chk("single_done_count", done_cnt - d0, 1);

    // Repeat with gap.
    d0 = done_cnt;
    send(3, 2, e);
    wait_idle("rep_gap");
    chk("rep_gap_done_count", done_cnt - d0, 1);

    // Back-to-back frames through a detector model.
    det_q.delete();
    send(2, 0, e);
    wait_idle("b2b");
    chk("det_hits", det_q.size(), 2);
    if (det_q.size() == 2) begin
      chk("det_first", det_q[0], e + 7);
      chk("det_spacing", det_q[1] - det_q[0], 7);
    end

    // Ignored requests: reps=0, mid-frame start, start while in DONE.
    send(0, 3, e);
    repeat (4) @(negedge clk);
    #1;
    chk("reps0_busy", int'(busy), 0);
    d0 = done_cnt;
    send(1, 0, e);
    b = e;
    send(2, 1, e);
    while (cyc < b + Len - 1) @(negedge clk);
    send(1, 0, e);
    chk("done_state_start_edge", e, b + Len + 1);
    wait_idle("ignored");
    chk("ignored_done_count", done_cnt - d0, 1);

    // Max reps and max gap.
    send(15, 7, e);
    wait_idle("max");

    // Abort after bit 4 of frame 1.
    send(2, 0, e);
    while (cyc < e + 4) @(negedge clk);
    #2;
    d0 = done_cnt;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("abort_outputs", int'({out, valid, busy, done}), 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    free_at = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    send(1, 0, e);
    wait_idle("after_abort");

    // Randomized requests, some aimed at the earliest accepting edge.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        while (cyc < free_at - 2) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      send($urandom_range(0, 5), $urandom_range(0, 7), e);
    end
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
